// File: rtl/rf_walker_arbiter.sv
// Round-robin arbiter sharing one refresh-interval walker among NUM_CH channels.
// Ports: clk, rst_n (async, active-low); ch_req/ch_feat in, ch_ack/ch_trefi/ch_valid out;
//        wk_start + six latched wk_* features out, wk_t_refi/wk_done in; busy, err out.
// Optional watchdog abort enabled by defining RF_ARB_WATCHDOG_EN.
module rf_walker_arbiter #(
    parameter int         NUM_CH        = 4,
    parameter logic [7:0] DEFAULT_TREFI = 8'd64,
    parameter int         TIMEOUT       = 80
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_CH-1:0]     ch_req,
    input  logic [48*NUM_CH-1:0]  ch_feat,
    output logic [NUM_CH-1:0]     ch_ack,
    output logic [8*NUM_CH-1:0]   ch_trefi,
    output logic [NUM_CH-1:0]     ch_valid,
    output logic                  wk_start,
    output logic [7:0]            wk_req_per_cycle,
    output logic [7:0]            wk_conflict_load,
    output logic [7:0]            wk_llc_miss,
    output logic [7:0]            wk_traffic_risk,
    output logic [7:0]            wk_rb_locality,
    output logic [7:0]            wk_rb_conflict,
    input  logic [7:0]            wk_t_refi,
    input  logic                  wk_done,
    output logic                  busy,
    output logic                  err
);

    localparam int PW = $clog2(NUM_CH);
    localparam logic [PW:0] NCH = (PW+1)'(NUM_CH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] gnt;
    logic [PW-1:0] pick;
    logic [PW:0]   idx;
    logic          any_req;
    logic [47:0]   pick_feat;
    logic          done_hit;
    logic          abort;
    logic          finish;

    // First requester at or above rr_ptr, wrapping around.
    always_comb begin
        any_req   = 1'b0;
        pick      = rr_ptr;
        pick_feat = '0;
        idx       = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = {1'b0, rr_ptr} + (PW+1)'(i);
            if (idx >= NCH)
                idx = idx - NCH;
            if (!any_req && ch_req[idx[PW-1:0]]) begin
                any_req = 1'b1;
                pick    = idx[PW-1:0];
            end
        end
        for (int k = 0; k < NUM_CH; k++) begin
            if (pick == PW'(k))
                pick_feat = ch_feat[48*k +: 48];
        end
    end

    assign done_hit = (state == WAIT) && wk_done;

`ifdef RF_ARB_WATCHDOG_EN
    logic [6:0] wd_cnt;

    // Counts completed WAIT cycles; the TIMEOUT-th one aborts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wd_cnt <= '0;
        else if (state != WAIT)
            wd_cnt <= '0;
        else
            wd_cnt <= wd_cnt + 7'd1;
    end

    // A done on the timeout edge wins over the abort.
    assign abort = (state == WAIT) && !wk_done && (wd_cnt == 7'(TIMEOUT-1));
`else
    assign abort = 1'b0;
`endif

    assign finish = done_hit || abort;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (any_req) state_n = WAIT;
            WAIT:    if (finish) state_n = RELEASE;
            RELEASE: if (!wk_done) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            rr_ptr           <= '0;
            gnt              <= '0;
            wk_start         <= 1'b0;
            wk_req_per_cycle <= '0;
            wk_conflict_load <= '0;
            wk_llc_miss      <= '0;
            wk_traffic_risk  <= '0;
            wk_rb_locality   <= '0;
            wk_rb_conflict   <= '0;
            ch_ack           <= '0;
            ch_trefi         <= '0;
            ch_valid         <= '0;
            busy             <= 1'b0;
            err              <= 1'b0;
        end else begin
            state  <= state_n;
            busy   <= (state_n != IDLE);
            ch_ack <= '0;
            err    <= abort;
            if (state == IDLE && any_req) begin
                gnt              <= pick;
                wk_start         <= 1'b1;
                wk_req_per_cycle <= pick_feat[7:0];
                wk_conflict_load <= pick_feat[15:8];
                wk_llc_miss      <= pick_feat[23:16];
                wk_traffic_risk  <= pick_feat[31:24];
                wk_rb_locality   <= pick_feat[39:32];
                wk_rb_conflict   <= pick_feat[47:40];
            end
            if (finish) begin
                wk_start <= 1'b0;
                rr_ptr   <= (gnt == PW'(NUM_CH-1)) ? '0 : gnt + PW'(1);
                for (int k = 0; k < NUM_CH; k++) begin
                    if (gnt == PW'(k)) begin
                        ch_ack[k]          <= 1'b1;
                        ch_valid[k]        <= 1'b1;
                        ch_trefi[8*k +: 8] <= wk_done ? wk_t_refi : DEFAULT_TREFI;
                    end
                end
            end
        end
    end

endmodule
